// File: rtl/riscv_multicycle_ctrl_if.sv
// Handshake/strobe bundle between the RV32I multicycle controller and its
// shared datapath.
//   master : controller side (consumes instr/zero/mem_ready, drives strobes)
//   slave  : datapath side (drives instr/zero/mem_ready, consumes strobes)
interface riscv_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [1:0]  immSel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  state_dbg;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, immSel,
           alu_src_b, alu_op, reg_we, wb_sel, fault, fault_code, state_dbg
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, immSel,
           alu_src_b, alu_op, reg_we, wb_sel, fault, fault_code, state_dbg
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core sharing one datapath and one
// unified memory port.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : master side of riscv_multicycle_ctrl_if (instr, zero,
//                mem_ready in; memory, PC/IR, ALU, regfile strobes,
//                fault status and state_dbg out)
//
// state | meaning
// 0     | FETCH  : read instruction at PC, wait for mem_ready
// 1     | DECODE : opcode check, immSel settles
// 2     | EXEC   : ALU op, branch / jump PC update
// 3     | MEM    : LW/SW data access at ALU address
// 4     | WB     : register file write
// 5     | ERR    : sticky fault, left only through rst_n
module riscv_multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                     clk,
  input logic                     rst_n,
  riscv_multicycle_ctrl_if.master bus
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5;
  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111;

  logic [2:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fault_q, fault_d;
  logic [1:0] fault_code_q, fault_code_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, illegal;
  logic [1:0] imm_dec;
  logic       br_f3_ok, br_taken;
  logic       unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};

  always_comb begin
    is_r    = (opcode == OP_R);
    is_i    = (opcode == OP_I);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_br   = (opcode == OP_BR);
    is_jal  = (opcode == OP_JAL);
    is_jalr = (opcode == OP_JALR);
    illegal = !(is_r || is_i || is_lw || is_sw || is_br || is_jal || is_jalr);
    imm_dec = 2'b00;
    if (is_sw)  imm_dec = 2'b01;
    if (is_br)  imm_dec = 2'b10;
    if (is_jal) imm_dec = 2'b11;
    // Only BEQ/BNE are supported; other funct3 values fault in EXEC.
    br_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
    br_taken = ((funct3 == 3'b000) && bus.zero) || ((funct3 == 3'b001) && !bus.zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= 8'd0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        // A ready arriving on the last allowed wait cycle still completes.
        if (bus.mem_ready) begin
          wait_cnt_d = 8'd0;
          if (state_q == S_FETCH) state_d = S_DECODE;
          else                    state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d      = S_ERR;
          fault_d      = 1'b1;
          fault_code_d = 2'b10;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d      = S_ERR;
          fault_d      = 1'b1;
          fault_code_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r || is_i || is_jal || is_jalr) state_d = S_WB;
        else if (is_lw || is_sw)               state_d = S_MEM;
        else if (is_br && br_f3_ok)            state_d = S_FETCH;
        else begin
          state_d      = S_ERR;
          fault_d      = 1'b1;
          fault_code_d = 2'b01;
        end
      end
      S_WB:  state_d = S_FETCH;
      S_ERR: state_d = S_ERR;
      default: begin
        state_d      = S_ERR;
        fault_d      = 1'b1;
        fault_code_d = 2'b01;
      end
    endcase
  end

  logic       mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, alu_src_b_o, reg_we_o;
  logic [1:0] pc_src_o, imm_sel_o, alu_op_o, wb_sel_o;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    addr_sel_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = 2'b00;
    imm_sel_o   = 2'b00;
    alu_src_b_o = 1'b0;
    alu_op_o    = 2'b00;
    reg_we_o    = 1'b0;
    wb_sel_o    = 2'b00;
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)
      imm_sel_o = imm_dec;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        // Reset forces FETCH; gating keeps the fetch strobes quiet while held.
        if (bus.mem_ready && rst_n) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r || is_i) begin
          alu_op_o    = 2'b10;
          alu_src_b_o = is_i;
        end else if (is_lw || is_sw) begin
          alu_src_b_o = 1'b1;
        end else if (is_br) begin
          alu_op_o = 2'b01;
          if (br_f3_ok && br_taken) begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'b01;
          end
        end else if (is_jal) begin
          pc_we_o  = 1'b1;
          pc_src_o = 2'b01;
        end else if (is_jalr) begin
          alu_src_b_o = 1'b1;
          pc_we_o     = 1'b1;
          pc_src_o    = 2'b10;
        end
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = is_sw;
      end
      S_WB: begin
        reg_we_o = 1'b1;
        if (is_lw)                wb_sel_o = 2'b01;
        else if (is_jal || is_jalr) wb_sel_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.mem_req    = mem_req_o;
  assign bus.mem_we     = mem_we_o;
  assign bus.addr_sel   = addr_sel_o;
  assign bus.ir_we      = ir_we_o;
  assign bus.pc_we      = pc_we_o;
  assign bus.pc_src     = pc_src_o;
  assign bus.immSel     = imm_sel_o;
  assign bus.alu_src_b  = alu_src_b_o;
  assign bus.alu_op     = alu_op_o;
  assign bus.reg_we     = reg_we_o;
  assign bus.wb_sel     = wb_sel_o;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl. A transaction-level model
// expands each instruction into its expected per-cycle output trace, which
// is then replayed against the DUT one cycle at a time.
module tb_riscv_multicycle_ctrl;
  localparam int MAXW = 15;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_ILL = 7;

  logic clk = 1'b0;
  logic rst_n;
  riscv_multicycle_ctrl_if bus();

  riscv_multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [20:0] exp_q [$];
  bit          rdy_q [$];
  string       tag_q [$];
  logic [31:0] cur_instr;
  bit          cur_zero;

  // {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, immSel,
  //  alu_src_b, alu_op, reg_we, wb_sel, fault, fault_code}
  function automatic logic [20:0] vec(int st, bit req, bit we, bit asel, bit irw,
                                      bit pcw, int pcs, int imm, bit asb, int aop,
                                      bit rw, int wb, bit flt, int fc);
    logic [2:0] s3;
    logic [1:0] p2, i2, a2, w2, f2;
    s3 = st[2:0]; p2 = pcs[1:0]; i2 = imm[1:0]; a2 = aop[1:0]; w2 = wb[1:0]; f2 = fc[1:0];
    return {s3, req, we, asel, irw, pcw, p2, i2, asb, a2, rw, w2, flt, f2};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.state_dbg, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we,
            bus.pc_we, bus.pc_src, bus.immSel, bus.alu_src_b, bus.alu_op,
            bus.reg_we, bus.wb_sel, bus.fault, bus.fault_code};
  endfunction

  task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic int classify(logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_ILL;
    endcase
  endfunction

  task automatic push(input logic [20:0] v, input bit r, input string t);
    exp_q.push_back(v); rdy_q.push_back(r); tag_q.push_back(t);
  endtask

  task automatic push_err(input int fc);
    for (int i = 0; i < 3; i++) push(vec(5,0,0,0,0,0,0,0,0,0,0,0,1,fc), 1'($urandom_range(0,1)), "err_hold");
  endtask

  // Expected trace of one instruction: fw/mw are the number of not-ready
  // cycles before the memory answers (beyond MAXW means no answer at all).
  task automatic model(input logic [31:0] ins, input bit z, input int fw, input int mw,
                       output bit faulted);
    int k, im, f3;
    bit taken;
    k  = classify(ins);
    im = (k == K_SW) ? 1 : (k == K_BR) ? 2 : (k == K_JAL) ? 3 : 0;
    f3 = int'(ins[14:12]);
    faulted = 1'b0;
    if (fw > MAXW) begin
      for (int i = 0; i <= MAXW; i++) push(vec(0,1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, "fetch_wait");
      push_err(2); faulted = 1'b1; return;
    end
    for (int i = 0; i < fw; i++) push(vec(0,1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, "fetch_wait");
    push(vec(0,1,0,0,1,1,0,0,0,0,0,0,0,0), 1'b1, "fetch_done");
    push(vec(1,0,0,0,0,0,0,im,0,0,0,0,0,0), 1'($urandom_range(0,1)), "decode");
    if (k == K_ILL) begin push_err(1); faulted = 1'b1; return; end
    case (k)
      K_R:    push(vec(2,0,0,0,0,0,0,im,0,2,0,0,0,0), 1'($urandom_range(0,1)), "exec_r");
      K_I:    push(vec(2,0,0,0,0,0,0,im,1,2,0,0,0,0), 1'($urandom_range(0,1)), "exec_i");
      K_LW, K_SW: push(vec(2,0,0,0,0,0,0,im,1,0,0,0,0,0), 1'($urandom_range(0,1)), "exec_mem");
      K_BR: begin
        taken = (f3 == 0 && z) || (f3 == 1 && !z);
        push(vec(2,0,0,0,0,taken,taken ? 1 : 0,im,0,1,0,0,0,0), 1'($urandom_range(0,1)), "exec_br");
        if (f3 > 1) begin push_err(1); faulted = 1'b1; end
        return;
      end
      K_JAL:  push(vec(2,0,0,0,0,1,1,im,0,0,0,0,0,0), 1'($urandom_range(0,1)), "exec_jal");
      default: push(vec(2,0,0,0,0,1,2,im,1,0,0,0,0,0), 1'($urandom_range(0,1)), "exec_jalr");
    endcase
    if (k == K_LW || k == K_SW) begin
      if (mw > MAXW) begin
        for (int i = 0; i <= MAXW; i++) push(vec(3,1,k == K_SW,1,0,0,0,im,0,0,0,0,0,0), 1'b0, "mem_wait");
        push_err(2); faulted = 1'b1; return;
      end
      for (int i = 0; i < mw; i++) push(vec(3,1,k == K_SW,1,0,0,0,im,0,0,0,0,0,0), 1'b0, "mem_wait");
      push(vec(3,1,k == K_SW,1,0,0,0,im,0,0,0,0,0,0), 1'b1, "mem_done");
      if (k == K_SW) return;
    end
    push(vec(4,0,0,0,0,0,0,im,0,0,1,(k == K_LW) ? 1 : (k == K_R || k == K_I) ? 0 : 2,0,0),
         1'($urandom_range(0,1)), "wb");
  endtask

  // Called at posedge+1; returns at posedge+1, or at the last negedge when stop_neg.
  task automatic run_q(input int limit, input bit stop_neg);
    int n;
    n = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      bus.instr     = cur_instr;
      bus.zero      = cur_zero;
      bus.mem_ready = rdy_q[i];
      @(negedge clk);
      chk(tag_q[i], obs(), exp_q[i]);
      if (!(stop_neg && i == n - 1)) begin
        @(posedge clk); #1;
      end
    end
    exp_q.delete(); rdy_q.delete(); tag_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1 chk("in_reset", obs(), vec(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    chk("in_reset_hold", obs(), vec(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic step(input logic [31:0] ins, input bit z, input int fw, input int mw);
    bit f;
    cur_instr = ins; cur_zero = z;
    model(ins, z, fw, mw, f);
    run_q(-1, 1'b0);
    if (f) do_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int k, fw, mw;
    bit f;
    rst_n = 1'b0;
    bus.instr = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    cur_instr = 32'h0; cur_zero = 1'b0;
    @(posedge clk); #1;
    do_reset();

    step(32'h002081B3, 1'b0, 0, 0);    // add
    step(32'h0000A183, 1'b0, 0, 3);    // lw, 3 wait cycles in MEM
    step(32'h0030A023, 1'b0, 0, 0);    // sw
    step(32'h00208463, 1'b1, 0, 0);    // beq taken
    step(32'h00208463, 1'b0, 0, 0);    // beq not taken
    step(32'h00209463, 1'b0, 1, 0);    // bne taken
    step(32'h008000EF, 1'b0, 0, 0);    // jal
    step(32'h000080E7, 1'b0, 2, 0);    // jalr
    step(32'h00108093, 1'b0, 0, 0);    // addi
    step(32'h002081B3, 1'b0, MAXW, 0); // ready on the timeout cycle wins
    step(32'h0000A183, 1'b0, 0, MAXW);
    step(32'h00000000, 1'b0, 0, 0);    // illegal opcode
    step(32'h002081B3, 1'b0, MAXW + 1, 0); // fetch timeout
    step(32'h0030A023, 1'b0, 0, MAXW + 1); // store timeout
    step(32'h0020C463, 1'b1, 0, 0);    // blt unsupported

    // Reset while a store waits in MEM: mem_we must drop immediately.
    cur_instr = 32'h0030A023; cur_zero = 1'b0;
    model(cur_instr, 1'b0, 0, 5, f);
    run_q(4, 1'b1);
    rst_n = 1'b0;
    #1 chk("reset_mid_mem", obs(), vec(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;

    for (int it = 0; it < 80; it++) begin
      r = $urandom;
      k = $urandom_range(0, 8);
      case (k)
        0: r[6:0] = 7'b0110011;
        1: r[6:0] = 7'b0010011;
        2: r[6:0] = 7'b0000011;
        3: r[6:0] = 7'b0100011;
        4: begin
          r[6:0] = 7'b1100011;
          if ($urandom_range(0, 3) != 0) r[14:13] = 2'b00;
        end
        5: r[6:0] = 7'b1101111;
        6: r[6:0] = 7'b1100111;
        default: ;
      endcase
      fw = ($urandom_range(0, 11) == 0) ? $urandom_range(MAXW, MAXW + 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 11) == 0) ? $urandom_range(MAXW, MAXW + 1) : $urandom_range(0, 3);
      step(r, 1'($urandom_range(0, 1)), fw, mw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
